// File: rtl/car_game_pkg.sv
// Shared types and constants for the car game video blocks.
// Screen geometry, sprite size, colour codes and the lateral move rule.
package car_game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_MOVE,
        S_DRAW,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam int SPRITE_W = 8;
    localparam int SPRITE_H = 8;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BG_COLOUR   = 3'b000;
    localparam logic [2:0] TRANSPARENT = 3'b101;

    // One lateral step, clamped to the road edges; both or neither = stay.
    function automatic logic [7:0] clamp_move(
        input logic [7:0] x,
        input logic       left,
        input logic       right,
        input logic [7:0] min_x,
        input logic [7:0] max_x,
        input logic [7:0] step
    );
        logic [7:0] lo_lim;
        logic [7:0] hi_lim;
        lo_lim = min_x + step;
        hi_lim = max_x - step;
        if (left && !right)
            return (x < lo_lim) ? min_x : x - step;
        else if (right && !left)
            return (x > hi_lim) ? max_x : x + step;
        else
            return x;
    endfunction

endpackage

// File: rtl/sprite_pix_count.sv
// Walks the 64 pixels of an 8x8 sprite box in row-major order.
// Flags the final pixel so the caller can change state on the same edge.
module sprite_pix_count (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clear,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last
);

    logic [5:0] k;

    always_ff @(posedge clk) begin
        if (reset || clear)
            k <= 6'd0;
        else if (en)
            k <= k + 6'd1;
    end

    assign row  = k[5:3];
    assign col  = k[2:0];
    assign last = (k == 6'd63);

endmodule

// File: rtl/car_sprite_draw.sv
// Player car renderer: erase old 8x8 box, move one step, redraw from ROM.
// Emits a pixel stream for the 160x120 3-bit VGA adapter write port.
module car_sprite_draw #(
    parameter logic [7:0] START_X     = 8'd76,
    parameter logic [6:0] CAR_Y       = 7'd100,
    parameter logic [7:0] MIN_X       = 8'd40,
    parameter logic [7:0] MAX_X       = 8'd112,
    parameter logic [7:0] STEP        = 8'd4,
    parameter logic [2:0] BG_COLOUR   = car_game_pkg::BG_COLOUR,
    parameter logic [2:0] TRANSPARENT = car_game_pkg::TRANSPARENT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       go,
    input  logic       left_req,
    input  logic       right_req,
    output logic [5:0] rom_addr,
    input  logic [2:0] rom_data,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic [7:0] car_x
);

    import car_game_pkg::*;

    state_t     state;
    logic [2:0] row;
    logic [2:0] col;
    logic       last;
    logic       cnt_en;
    logic       cnt_clear;

    logic [7:0] px_x;
    logic [6:0] px_y;
    logic [2:0] px_colour;
    logic       erase_q;
    logic       draw_q;
    logic       rom_opaque;

    assign cnt_en    = (state == S_ERASE) || (state == S_DRAW);
    assign cnt_clear = (state == S_IDLE);

    sprite_pix_count u_count (
        .clk   (Clock),
        .reset (Reset),
        .en    (cnt_en),
        .clear (cnt_clear),
        .row   (row),
        .col   (col),
        .last  (last)
    );

    // ROM data lands one cycle after its address, alongside the delayed x/y.
    assign rom_opaque = draw_q && (rom_data != TRANSPARENT);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            car_x     <= START_X;
            px_x      <= 8'd0;
            px_y      <= 7'd0;
            px_colour <= 3'd0;
            erase_q   <= 1'b0;
            draw_q    <= 1'b0;
        end else begin
            erase_q <= 1'b0;
            draw_q  <= 1'b0;
            if (rom_opaque)
                px_colour <= rom_data;
            unique case (state)
                S_IDLE: begin
                    if (go)
                        state <= S_ERASE;
                end
                S_ERASE: begin
                    px_x      <= car_x + {5'd0, col};
                    px_y      <= CAR_Y + {4'd0, row};
                    px_colour <= BG_COLOUR;
                    erase_q   <= 1'b1;
                    if (last)
                        state <= S_MOVE;
                end
                S_MOVE: begin
                    car_x <= clamp_move(car_x, left_req, right_req,
                                        MIN_X, MAX_X, STEP);
                    state <= S_DRAW;
                end
                S_DRAW: begin
                    px_x   <= car_x + {5'd0, col};
                    px_y   <= CAR_Y + {4'd0, row};
                    draw_q <= 1'b1;
                    if (last)
                        state <= S_FLUSH;
                end
                S_FLUSH: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rom_addr   = {row, col};
    assign vga_x      = px_x;
    assign vga_y      = px_y;
    assign vga_colour = rom_opaque ? rom_data : px_colour;
    assign plot       = erase_q | rom_opaque;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_car_sprite_draw.sv
// Randomized bench for car_sprite_draw against a per-cycle pixel model.
// Cycle n is the clock period ending at edge n, counted from the go edge.
module tb_car_sprite_draw;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       go;
    logic       left_req;
    logic       right_req;
    logic [5:0] rom_addr;
    logic [2:0] rom_data;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic [7:0] car_x;

    car_sprite_draw dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .go         (go),
        .left_req   (left_req),
        .right_req  (right_req),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done),
        .car_x      (car_x)
    );

    always #5 Clock = ~Clock;

    logic [2:0] rom [64];
    always @(posedge Clock) rom_data <= rom[rom_addr];

    localparam int NCYC = 141;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cx = 76;

    logic       o_plot [NCYC];
    logic       o_busy [NCYC];
    logic       o_done [NCYC];
    logic [7:0] o_x    [NCYC];
    logic [6:0] o_y    [NCYC];
    logic [2:0] o_col  [NCYC];

    logic       e_plot [NCYC];
    logic       e_busy [NCYC];
    logic       e_done [NCYC];
    logic [7:0] e_x    [NCYC];
    logic [6:0] e_y    [NCYC];
    logic [2:0] e_col  [NCYC];

    function automatic int next_x(input int cx, input bit l, input bit r);
        if (l && !r) return (cx - 4 < 40) ? 40 : cx - 4;
        if (r && !l) return (cx + 4 > 112) ? 112 : cx + 4;
        return cx;
    endfunction

    task automatic fill_rom(input int mode);
        for (int k = 0; k < 64; k++) begin
            if (mode == 0)
                rom[k] = 3'($urandom_range(0, 7));
            else
                rom[k] = (k == 9) ? 3'b101 : 3'($urandom_range(0, 4));
        end
    endtask

    // Drive one update and record every output for cycles 1..NCYC-1.
    task automatic run_update(input bit l, input bit r, input int go_again);
        @(negedge Clock);
        go = 1'b1;
        left_req = l;
        right_req = r;
        @(posedge Clock);
        o_plot[0] = 1'b0;
        o_busy[0] = 1'b0;
        o_done[0] = 1'b0;
        for (int c = 1; c < NCYC; c++) begin
            @(negedge Clock);
            o_plot[c] = plot;
            o_busy[c] = busy;
            o_done[c] = done;
            o_x[c]    = vga_x;
            o_y[c]    = vga_y;
            o_col[c]  = vga_colour;
            go = (go_again > 0 && c == go_again);
        end
        go = 1'b0;
        left_req = 1'b0;
        right_req = 1'b0;
    endtask

    // Expected stream: erase box in cycles 2..65, draw box in 67..130.
    task automatic build_expected(input bit l, input bit r);
        int ncx;
        for (int c = 0; c < NCYC; c++) begin
            e_plot[c] = 1'b0;
            e_busy[c] = (c >= 1 && c <= 131);
            e_done[c] = (c == 131);
            e_x[c] = 8'd0;
            e_y[c] = 7'd0;
            e_col[c] = 3'd0;
        end
        for (int k = 0; k < 64; k++) begin
            e_plot[k + 2] = 1'b1;
            e_x[k + 2]    = 8'(model_cx + k % 8);
            e_y[k + 2]    = 7'(100 + k / 8);
            e_col[k + 2]  = 3'b000;
        end
        ncx = next_x(model_cx, l, r);
        for (int k = 0; k < 64; k++) begin
            if (rom[k] != 3'b101) begin
                e_plot[k + 67] = 1'b1;
                e_x[k + 67]    = 8'(ncx + k % 8);
                e_y[k + 67]    = 7'(100 + k / 8);
                e_col[k + 67]  = rom[k];
            end
        end
        model_cx = ncx;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        go = 1'b0;
        left_req = 1'b0;
        right_req = 1'b0;
        for (int k = 0; k < 64; k++) rom[k] = 3'd0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        model_cx = 76;
        @(negedge Clock);
        n_checks += 6;
        if (car_x !== 8'd76) begin
            n_fail++;
            $display("FAIL reset_car_x: got %0d want 76", car_x);
        end
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: plot=%b busy=%b done=%b want 000",
                     plot, busy, done);
        end
        if (vga_x !== 8'd0 || vga_y !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_xy: got %0d,%0d want 0,0", vga_x, vga_y);
        end
        if (vga_colour !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_colour: got %0d want 0", vga_colour);
        end
        if (rom_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_rom_addr: got %0d want 0", rom_addr);
        end
        if (dut.state !== car_game_pkg::S_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want IDLE", dut.state);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            n_checks++;
            if (plot !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet[%0d]: plot=%b busy=%b want 0 0",
                         i, plot, busy);
            end
        end
    endtask

    // Directed no-move, right and left sweeps into both clamps, both keys,
    // then random keys; every frame uses a fresh random ROM.
    task automatic test_frames(input int n_random);
        bit l;
        bit r;
        int total;
        total = 32 + n_random;
        for (int s = 0; s < total; s++) begin
            if (s == 0)       begin l = 0; r = 0; end
            else if (s <= 10) begin l = 0; r = 1; end
            else if (s <= 30) begin l = 1; r = 0; end
            else if (s == 31) begin l = 1; r = 1; end
            else begin
                l = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
            end
            fill_rom(0);
            run_update(l, r, 0);
            build_expected(l, r);
            for (int c = 1; c < NCYC; c++) begin
                n_checks++;
                if (o_plot[c] !== e_plot[c]) begin
                    n_fail++;
                    $display("FAIL frame%0d_plot c%0d: got %b want %b",
                             s, c, o_plot[c], e_plot[c]);
                end
                n_checks++;
                if (o_busy[c] !== e_busy[c] || o_done[c] !== e_done[c]) begin
                    n_fail++;
                    $display("FAIL frame%0d_busy_done c%0d: got %b%b want %b%b",
                             s, c, o_busy[c], o_done[c], e_busy[c], e_done[c]);
                end
                if (e_plot[c]) begin
                    n_checks++;
                    if (o_x[c] !== e_x[c] || o_y[c] !== e_y[c] ||
                        o_col[c] !== e_col[c]) begin
                        n_fail++;
                        $display("FAIL frame%0d_pixel c%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                                 s, c, o_x[c], o_y[c], o_col[c],
                                 e_x[c], e_y[c], e_col[c]);
                    end
                end
            end
            n_checks++;
            if (car_x !== 8'(model_cx)) begin
                n_fail++;
                $display("FAIL frame%0d_car_x: got %0d want %0d",
                         s, car_x, model_cx);
            end
        end
    endtask

    task automatic test_transparent;
        int draws;
        int hole;
        fill_rom(1);
        run_update(0, 0, 0);
        build_expected(0, 0);
        draws = 0;
        hole = 0;
        for (int c = 67; c <= 130; c++) begin
            if (o_plot[c] === 1'b1) begin
                draws++;
                if (o_x[c] == 8'(model_cx + 1) && o_y[c] == 7'd101)
                    hole++;
            end
        end
        n_checks += 3;
        if (draws != 63) begin
            n_fail++;
            $display("FAIL transp_count: got %0d draws want 63", draws);
        end
        if (hole != 0) begin
            n_fail++;
            $display("FAIL transp_hole: got %0d plots at addr 9 want 0", hole);
        end
        if (o_plot[76] !== 1'b0) begin
            n_fail++;
            $display("FAIL transp_cycle76: got plot=%b want 0", o_plot[76]);
        end
    endtask

    task automatic test_go_while_busy;
        int dones;
        int late_busy;
        int plots;
        int eplots;
        int when [2];
        when[0] = 10;
        when[1] = 131;
        for (int t = 0; t < 2; t++) begin
            fill_rom(0);
            run_update(0, 1, when[t]);
            build_expected(0, 1);
            dones = 0;
            late_busy = 0;
            plots = 0;
            eplots = 0;
            for (int c = 1; c < NCYC; c++) begin
                if (o_done[c] === 1'b1) dones++;
                if (c > 131 && o_busy[c] !== 1'b0) late_busy++;
                if (o_plot[c] === 1'b1) plots++;
                if (e_plot[c]) eplots++;
            end
            n_checks += 4;
            if (dones != 1) begin
                n_fail++;
                $display("FAIL gobusy%0d_dones: got %0d want 1", t, dones);
            end
            if (late_busy != 0) begin
                n_fail++;
                $display("FAIL gobusy%0d_restart: got %0d busy cycles after done want 0",
                         t, late_busy);
            end
            if (plots != eplots) begin
                n_fail++;
                $display("FAIL gobusy%0d_plots: got %0d want %0d", t, plots, eplots);
            end
            if (car_x !== 8'(model_cx)) begin
                n_fail++;
                $display("FAIL gobusy%0d_car_x: got %0d want %0d", t, car_x, model_cx);
            end
        end
    endtask

    task automatic test_reset_mid;
        fill_rom(0);
        @(negedge Clock);
        go = 1'b1;
        left_req = 1'b0;
        right_req = 1'b0;
        @(posedge Clock);
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clock);
            go = 1'b0;
            if (c == 20) begin
                n_checks++;
                if (plot !== 1'b1 || vga_x !== 8'(model_cx + 2) ||
                    vga_y !== 7'd102) begin
                    n_fail++;
                    $display("FAIL midrst_before: got plot=%b (%0d,%0d) want 1 (%0d,102)",
                             plot, vga_x, vga_y, model_cx + 2);
                end
                Reset = 1'b1;
            end
        end
        @(negedge Clock);
        n_checks += 3;
        if (plot !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_plot: got %b want 0", plot);
        end
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_busy: busy=%b done=%b want 0 0", busy, done);
        end
        if (car_x !== 8'd76) begin
            n_fail++;
            $display("FAIL midrst_car_x: got %0d want 76", car_x);
        end
        Reset = 1'b0;
        model_cx = 76;
        repeat (5) @(negedge Clock);
        n_checks++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: plot=%b busy=%b want 0 0", plot, busy);
        end
    endtask

    initial begin
        test_reset();
        test_frames(10);
        test_transparent();
        test_go_while_busy();
        test_reset_mid();
        test_frames(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/car_sprite_draw.md
Name: car_sprite_draw

Overview:
- Renders the player car sprite, 8x8 pixels, over the scrolling road.
- On each scroll tick it erases the car's old 8x8 box with road colour, applies one lateral move, then redraws the sprite from a colour ROM.
- Produces a pixel stream (x, y, colour, plot) for the 160x120, 3-bit-colour VGA adapter write port, running alongside the background scroller.

Parameters:
- START_X, 76: car x position after reset.
- CAR_Y, 100: fixed top row of the car. Must be ≤ 112.
- MIN_X, 40: leftmost legal car x (left road edge).
- MAX_X, 112: rightmost legal car x. Must be ≤ 152.
- STEP, 4: pixels moved per accepted move request.
- BG_COLOUR, 3'b000: colour written during erase.
- TRANSPARENT, 3'b101: ROM colour value that is never plotted.

Ports:
- Clock, in, 1: system clock (CLOCK_50 domain).
- Reset, in, 1: synchronous, active-high reset.
- go, in, 1: one-cycle scroll-tick pulse that starts an update.
- left_req, in, 1: move-left level from the keyboard decoder.
- right_req, in, 1: move-right level from the keyboard decoder.
- rom_addr, out, 6: sprite ROM address {row[2:0], col[2:0]}.
- rom_data, in, 3: sprite ROM colour. Valid one cycle after rom_addr.
- vga_x, out, 8: pixel x.
- vga_y, out, 7: pixel y.
- vga_colour, out, 3: pixel colour.
- plot, out, 1: write strobe for the current pixel.
- busy, out, 1: high whenever state ≠ IDLE.
- done, out, 1: one-cycle pulse when the update completes.
- car_x, out, 8: current car x, for collision logic.

Behaviour:
- Reset, sampled on a rising edge of Clock:
  - state = IDLE; car_x = START_X.
  - rom_addr, vga_x, vga_y, vga_colour, plot, busy, done all = 0.
- Reset mid-operation aborts immediately: plot = 0 from the next cycle. Partially drawn pixels remain on screen; this is accepted.
- States: IDLE → ERASE → MOVE → DRAW → FLUSH → DONE → IDLE.
- IDLE:
  - Waits for go.
  - go is accepted only in IDLE; go while busy is ignored, with no queueing.
- ERASE, 64 cycles:
  - A 6-bit counter k runs 0..63, with row = k[5:3] and col = k[2:0].
  - Pipeline stage registers x = car_x + col, y = CAR_Y + row, colour = BG_COLOUR.
  - The outputs show that pixel with plot = 1 one cycle later, giving the same one-cycle latency as the DRAW path.
  - On k = 63 the state goes to MOVE and the counter wraps to 0.
- MOVE, 1 cycle:
  - Samples left_req and right_req.
  - left only: car_x ← (car_x < MIN_X+STEP) ? MIN_X : car_x − STEP.
  - right only: car_x ← (car_x > MAX_X−STEP) ? MAX_X : car_x + STEP.
  - Both or neither: car_x is unchanged.
  - plot shows the last erase pixel this cycle.
- DRAW, 64 cycles:
  - rom_addr = k.
  - The delayed x/y (using the updated car_x) pair with rom_data on the next cycle.
  - plot = 1 unless rom_data == TRANSPARENT.
- FLUSH, 1 cycle: outputs the last draw pixel.
- DONE, 1 cycle: done = 1, plot = 0, then IDLE.
- Timing, with go sampled at edge 0:
  - ERASE occupies cycles 1–64; erase pixels appear in cycles 2–65.
  - MOVE is cycle 65. DRAW occupies cycles 66–129; draw pixels appear in cycles 67–130.
  - FLUSH is cycle 130; done is high in cycle 131.
- Latency and idle outputs:
  - Total latency is 131 cycles; busy is high in cycles 1–131.
  - plot = 0 in IDLE and DONE.
  - vga_x, vga_y and vga_colour hold their last values when plot = 0.
- Width and range:
  - All x arithmetic is 8-bit and y arithmetic is 7-bit, with no overflow given the parameter ranges.
  - car_x always stays within [MIN_X, MAX_X].

Decomposition:
- Shared package (car_game_pkg):
  - State encoding enum.
  - SPRITE_W = 8, SPRITE_H = 8.
  - SCREEN_W = 160, SCREEN_H = 120.
  - Colour constants: BG_COLOUR, TRANSPARENT.
- One sub-module: sprite_pix_count.
  - 6-bit counter with enable and synchronous clear.
  - Outputs row, col, and a last flag (k == 63).

Test Plan:
- Reset, then release: car_x = 76, plot = 0, busy = 0, done = 0. Hold 10 idle cycles → plot stays 0.
- go with no move request:
  - 64 erase plots over x 76..83, y 100..107, colour 000, in row-major order, in cycles 2–65.
  - 64 draw plots at the same box carrying the ROM colours, in cycles 67–130.
  - done pulses in cycle 131.
- right_req held with car_x = 76: draw box at x 80..87 and car_x = 80. With car_x = 110 → car_x = 112 (clamp). Repeat at 112 → car_x stays 112.
- left_req held with car_x = 42 → car_x = 40. left_req and right_req both high → car_x unchanged.
- ROM model returns 3'b101 at addr 9 → no plot for (car_x+1, 101) in DRAW. The other 63 draw pixels are plotted.
- Robustness:
  - go pulsed during ERASE → ignored; exactly one done pulse.
  - Reset asserted in ERASE cycle 20 → plot = 0 next cycle, state IDLE, car_x = 76, busy = 0.
